hdb3_vdet: RTL
==============

# hdb3_vdet

HDB3 receive front-end that converts the dual-rail bipolar line signal (P/N rails from the line interface) into the 2-bit symbol code consumed by the downstream V/B deletion stage. It sits directly upstream of that stage. It tracks pulse polarity to flag violation (V) pulses, and checks line-code rules (rail clash, zero runs, V alternation). Output code: 00 = zero, 01 = mark, 11 = V pulse; 10 is never produced.

## Interface
Parameters:
- ZRUN_MAX, 3: longest legal run of consecutive zero symbols.
- ERRCNT_W, 16: width of the error counter (only present with the macro).

Ports:
- clk  input  1  bit-rate clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  input  1  p_in/n_in carry one bit period this cycle.
- p_in  input  1  positive-rail pulse.
- n_in  input  1  negative-rail pulse.
- code  output  2  symbol code to the downstream stage.
- code_valid  output  1  code is valid this cycle.
- rail_err  output  1  one-cycle pulse: p_in and n_in were both high.
- zrun_err  output  1  one-cycle pulse: zero run exceeded ZRUN_MAX.
- valt_err  output  1  one-cycle pulse: V pulse had the same polarity as the previous V.
- err_cnt  output  ERRCNT_W  saturating error count (only with HDB3_VDET_ERRCNT_EN).

## Operation
- Polarity state last_pol ∈ {NONE, POS, NEG}. Reset value: NONE.
- V-polarity state last_v ∈ {NONE, POS, NEG}. Reset value: NONE.
- Zero-run counter zrun has width clog2(ZRUN_MAX+2) and saturates at ZRUN_MAX+1. Reset value: 0.
- Per accepted symbol (in_valid=1):
  - p=0, n=0: code=00. zrun increments. If the increment takes zrun to exactly ZRUN_MAX+1, zrun_err pulses once per run. last_pol is unchanged.
  - Exactly one rail high: pulse polarity pp. zrun clears.
    - last_pol==NONE: code=01.
    - pp != last_pol: code=01 (alternating mark or B pulse).
    - pp == last_pol: code=11 (V). If last_v == pp, valt_err pulses. last_v updates to pp.
    - In all cases last_pol updates to pp.
  - p=1, n=1: code=00 and rail_err pulses. last_pol, last_v and zrun are unchanged.
- in_valid=0: no state changes. code_valid=0 and code holds its last value.
- The block performs no B removal and no V deletion; those belong to the downstream stage.

## Timing
- All outputs are registered. code, code_valid and the error pulses appear on the clk edge after the accepting edge (latency 1).
- Reset values: code=00, code_valid=0, all error pulses 0, err_cnt=0.
- Back-to-back in_valid is sustained at 1 symbol/cycle with no stall.
- Async reset asserted mid-stream clears all state immediately. The first pulse after reset is always code 01, even if it is actually a V; this is accepted.
- Only one error pulse can occur per symbol: rail_err and zrun_err are mutually exclusive by construction.

## Configuration
- HDB3_VDET_ERRCNT_EN defined:
  - Adds port err_cnt.
  - err_cnt increments by 1 on any cycle where rail_err, zrun_err or valt_err is asserted.
  - err_cnt saturates at all-ones.
  - err_cnt clears only on reset.
- Undefined: the err_cnt port and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package hdb3_pkg holds:
  - Code constants: HDB3_ZERO=2'b00, HDB3_MARK=2'b01, HDB3_V=2'b11.
  - The polarity enum: NONE, POS, NEG.
  - These constants are shared with the encoder and the V/B deletion stage.
- One natural sub-module, hdb3_err_cnt: the saturating counter, instantiated only under the macro.

## Test plan
- Reset, then P,N,P,N with in_valid=1 → code 01,01,01,01 with latency 1; no errors.
- Sequence P,0,0,0,P (HDB3 for 1 0000 after a positive mark) → codes 01,00,00,00,11; no errors.
- P then 0,0,0,0 → the fourth zero produces zrun_err for one cycle; a fifth zero produces no second pulse; err_cnt=1 with the macro defined.
- p_in=n_in=1 → code 00 and rail_err=1. The next N after a previous P is still coded 01, proving last_pol is untouched.
- Two V pulses of the same polarity (P,P,N,P,P) → codes 01,11,01,01,11 with valt_err on the last symbol. With the macro, drive 2^ERRCNT_W+5 rail errors → err_cnt holds at all-ones.
- Assert rst_n low mid-run with zrun=2 → all outputs are 0 immediately. After release, 0,0 produces no zrun_err, and the first pulse codes 01.

Source files
------------

// File: rtl/hdb3_pkg.sv
// rtl/hdb3_pkg.sv - shared HDB3 symbol codes, polarity enum and helpers
package hdb3_pkg;

  // Symbol codes passed between encoder, front-end and V/B deletion stage
  localparam logic [1:0] HDB3_ZERO = 2'b00;
  localparam logic [1:0] HDB3_MARK = 2'b01;
  localparam logic [1:0] HDB3_V    = 2'b11;

  // Polarity of the last seen pulse (NONE until the first pulse after reset)
  typedef enum logic [1:0] {
    NONE = 2'b00,
    POS  = 2'b01,
    NEG  = 2'b10
  } pol_e;

  // Polarity of a single-rail pulse; only meaningful when exactly one rail is high
  function automatic pol_e rail_pol(input logic p);
    return p ? POS : NEG;
  endfunction

endpackage

// File: rtl/hdb3_err_cnt.sv
// rtl/hdb3_err_cnt.sv - saturating line-code error counter
module hdb3_err_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count one per flagged cycle, sticking at all-ones; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hdb3_vdet.sv
// rtl/hdb3_vdet.sv - HDB3 dual-rail receive front-end with V detection (HDB3_VDET_ERRCNT_EN adds err_cnt)
module hdb3_vdet
  import hdb3_pkg::*;
#(
  parameter int ZRUN_MAX = 3
`ifdef HDB3_VDET_ERRCNT_EN
  ,
  parameter int ERRCNT_W = 16
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                p_in,
  input  logic                n_in,
  output logic [1:0]          code,
  output logic                code_valid,
  output logic                rail_err,
  output logic                zrun_err,
  output logic                valt_err
`ifdef HDB3_VDET_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt
`endif
);

  // Zero-run counter saturates one past the legal maximum so the error fires once per run
  localparam int            ZW    = $clog2(ZRUN_MAX + 2);
  localparam logic [ZW-1:0] ZLAST = ZW'(ZRUN_MAX);
  localparam logic [ZW-1:0] ZSAT  = ZW'(ZRUN_MAX + 1);

  pol_e          last_pol, last_pol_nxt;
  pol_e          last_v, last_v_nxt;
  pol_e          pp;
  logic [ZW-1:0] zrun, zrun_nxt;
  logic [1:0]    code_nxt;
  logic          rail_nxt, zrun_err_nxt, valt_nxt;

  // Classify the incoming bit period and derive next line-code state
  always_comb begin
    last_pol_nxt = last_pol;
    last_v_nxt   = last_v;
    zrun_nxt     = zrun;
    code_nxt     = HDB3_ZERO;
    rail_nxt     = 1'b0;
    zrun_err_nxt = 1'b0;
    valt_nxt     = 1'b0;
    pp           = rail_pol(p_in);
    if (in_valid) begin
      if (p_in && n_in) begin
        // Rail clash: report it but leave all tracking state alone
        rail_nxt = 1'b1;
      end else if (!p_in && !n_in) begin
        if (zrun != ZSAT) begin
          zrun_nxt = zrun + 1'b1;
          if (zrun == ZLAST) begin
            zrun_err_nxt = 1'b1;
          end
        end
      end else begin
        zrun_nxt     = '0;
        last_pol_nxt = pp;
        if (last_pol == pp) begin
          // Same polarity as previous pulse: bipolar violation
          code_nxt   = HDB3_V;
          last_v_nxt = pp;
          if (last_v == pp) begin
            valt_nxt = 1'b1;
          end
        end else begin
          code_nxt = HDB3_MARK;
        end
      end
    end
  end

  // Tracking state: polarity history and zero-run length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pol <= NONE;
      last_v   <= NONE;
      zrun     <= '0;
    end else begin
      last_pol <= last_pol_nxt;
      last_v   <= last_v_nxt;
      zrun     <= zrun_nxt;
    end
  end

  // Registered outputs; code holds across idle cycles, pulses last one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code       <= HDB3_ZERO;
      code_valid <= 1'b0;
      rail_err   <= 1'b0;
      zrun_err   <= 1'b0;
      valt_err   <= 1'b0;
    end else begin
      code_valid <= in_valid;
      rail_err   <= rail_nxt;
      zrun_err   <= zrun_err_nxt;
      valt_err   <= valt_nxt;
      if (in_valid) begin
        code <= code_nxt;
      end
    end
  end

`ifdef HDB3_VDET_ERRCNT_EN
  logic err_any;

  // Any reported error pulse advances the counter
  always_comb begin
    err_any = rail_err | zrun_err | valt_err;
  end

  hdb3_err_cnt #(
    .W(ERRCNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (err_any),
    .cnt  (err_cnt)
  );
`endif

endmodule
